wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 93 +++++++++
 tb/tb_wb_regfile.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// General-purpose register file fed by the writeback stage: one write port,
// two combinational read ports with same-cycle write bypass, and a commit counter.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_write_reg_en_i,
    input  logic [ADDR_W-1:0] wb_write_reg_addr_i,
    input  logic [DATA_W-1:0] wb_write_reg_data_i,
    input  logic              rd1_en_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic              rd2_en_i,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic [DATA_W-1:0] rd2_data_o,
    output logic [31:0]       wb_commit_cnt_o
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [31:0]       commit_cnt_r;
    logic              wr_commit_s;

    // Read-port resolution in priority order: reset, enable, x0, bypass, storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_act,
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (!rst_act) begin
            val = {DATA_W{1'b0}};
        end else if (!en) begin
            val = {DATA_W{1'b0}};
        end else if (addr == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (wr_en && (wr_addr == addr)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // A write commits only when enabled and not aimed at the hardwired-zero register.
    always_comb begin
        wr_commit_s = 1'b0;
        if (wb_write_reg_en_i && (wb_write_reg_addr_i != {ADDR_W{1'b0}})) begin
            wr_commit_s = 1'b1;
        end else begin
            wr_commit_s = 1'b0;
        end
    end

    // Register storage; entry 0 is cleared on reset and never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_commit_s) begin
            regs_r[wb_write_reg_addr_i] <= wb_write_reg_data_i;
        end
    end

    // Wrapping count of committed writebacks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_cnt_r <= 32'd0;
        end else if (wr_commit_s) begin
            commit_cnt_r <= commit_cnt_r + 32'd1;
        end
    end

    assign wb_commit_cnt_o = commit_cnt_r;

    // Both read ports apply identical rules independently.
    always_comb begin
        rd1_data_o = {DATA_W{1'b0}};
        rd2_data_o = {DATA_W{1'b0}};
        rd1_data_o = read_port(rst, rd1_en_i, rd1_addr_i, wb_write_reg_en_i,
                               wb_write_reg_addr_i, wb_write_reg_data_i, regs_r[rd1_addr_i]);
        rd2_data_o = read_port(rst, rd2_en_i, rd2_addr_i, wb_write_reg_en_i,
                               wb_write_reg_addr_i, wb_write_reg_data_i, regs_r[rd2_addr_i]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: vector table plus hand-written
// sequences for asynchronous reset and counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        r1en;
    logic [4:0]  r1addr;
    logic [31:0] r1data;
    logic        r2en;
    logic [4:0]  r2addr;
    logic [31:0] r2data;
    logic [31:0] cnt;

    int checks;
    int errors;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        r1en;
        logic [4:0]  r1addr;
        logic        r2en;
        logic [4:0]  r2addr;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expcnt;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_write_reg_en_i   (we),
        .wb_write_reg_addr_i (waddr),
        .wb_write_reg_data_i (wdata),
        .rd1_en_i            (r1en),
        .rd1_addr_i          (r1addr),
        .rd1_data_o          (r1data),
        .rd2_en_i            (r2en),
        .rd2_addr_i          (r2addr),
        .rd2_data_o          (r2data),
        .wb_commit_cnt_o     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        r1en = e1; r1addr = a1; r2en = e2; r2addr = a2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // we, waddr, wdata, r1en, r1addr, r2en, r2addr, exp1, exp2, expcnt
        vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  1'b1, 5'd31, 32'h0,         32'h0,         32'd0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF,  1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF,  32'h0,         32'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF,  32'h0,         32'd1};
        vecs[3]  = '{1'b1, 5'd7,  32'h12345678,  1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678,  32'h12345678,  32'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678,  32'h12345678,  32'd2};
        vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF,  32'h0,         32'd2};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd0,  32'h12345678,  32'h0,         32'd2};
        vecs[7]  = '{1'b0, 5'd5,  32'h0,         1'b1, 5'd5,  1'b1, 5'd7,  32'hDEADBEEF,  32'h12345678,  32'd2};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 5'd1,  32'hDEADBEEF,  32'h0,         32'd2};
        vecs[9]  = '{1'b1, 5'd9,  32'h00000001,  1'b1, 5'd9,  1'b1, 5'd5,  32'h00000001,  32'hDEADBEEF,  32'd2};
        vecs[10] = '{1'b1, 5'd9,  32'hCAFE0000,  1'b1, 5'd9,  1'b0, 5'd9,  32'hCAFE0000,  32'h0,         32'd3};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b1, 5'd31, 32'hCAFE0000,  32'h0,         32'd4};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd7,  1'b1, 5'd7,  32'h0,         32'h12345678,  32'd4};

        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd31);
        #1;
        check("reset rd1", r1data, 32'h0);
        check("reset rd2", r2data, 32'h0);
        check("reset cnt", cnt, 32'd0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].r1en, vecs[i].r1addr, vecs[i].r2en, vecs[i].r2addr);
            #1;
            check($sformatf("v%0d rd1", i), r1data, vecs[i].exp1);
            check($sformatf("v%0d rd2", i), r2data, vecs[i].exp2);
            check($sformatf("v%0d cnt", i), cnt, vecs[i].expcnt);
        end

        // Commit to x3, then assert reset between edges.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 1'b1, 5'd7);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7);
        #1;
        check("pre-reset rd1", r1data, 32'hA5A5A5A5);
        check("pre-reset cnt", cnt, 32'd5);
        #1;
        rst = 1'b0;
        #1;
        check("async reset rd1", r1data, 32'h0);
        check("async reset rd2", r2data, 32'h0);
        check("async reset cnt", cnt, 32'd0);
        // A write presented while in reset must be dropped.
        drive(1'b1, 5'd4, 32'h11111111, 1'b1, 5'd3, 1'b1, 5'd4);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
        rst = 1'b1;
        #1;
        check("post-reset rd1 x3", r1data, 32'h0);
        check("post-reset rd2 x4", r2data, 32'h0);
        check("post-reset cnt", cnt, 32'd0);
        check("post-reset x7", dut.regs_r[7], 32'h0);
        // First edge after release commits.
        drive(1'b1, 5'd4, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3);
        #1;
        check("first commit rd1", r1data, 32'h0BADF00D);
        check("first commit rd2", r2data, 32'h0);
        check("first commit cnt", cnt, 32'd1);

        // Preload the counter to its maximum and commit once more.
        @(negedge clk);
        force dut.commit_cnt_r = 32'hFFFFFFFF;
        #1;
        release dut.commit_cnt_r;
        #1;
        check("preload cnt", cnt, 32'hFFFFFFFF);
        drive(1'b1, 5'd2, 32'h00C0FFEE, 1'b0, 5'd2, 1'b1, 5'd2);
        #1;
        check("rd1 disabled on bypass", r1data, 32'h0);
        check("rd2 bypass x2", r2data, 32'h00C0FFEE);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd2);
        #1;
        check("wrap cnt", cnt, 32'h0);
        check("wrap rd1 x2", r1data, 32'h00C0FFEE);
        check("rd2 disabled x2", r2data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
